matrix_unloader: RTL and testbench
==================================

# matrix_unloader

Reads one 4x4 matrix of 16-bit elements out of the output register and streams it element by element over a valid/ready interface, row-major. It is the consuming end of the output register: it pulses `read_data`, snapshots the 256-bit matrix, then serializes it to a downstream sink such as a debug port, UART bridge or testbench monitor. It frees the datapath to overwrite the output register as soon as the snapshot is taken.

## Interface
- `ELEM_W`, 16: element width in bits.
- `DIM`, 4: matrix dimension. The matrix holds DIM*DIM elements, MAT_W = DIM*DIM*ELEM_W (256).
- `clk`, in, 1: system clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: unload request. Sampled only in IDLE.
- `read_data`, out, 1: read strobe to the output register. One-cycle pulse.
- `data`, in, MAT_W: matrix from the output register.
- `out_data`, out, ELEM_W: current element.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: sink accepts the element.
- `out_row`, out, 2: row index of the current element.
- `out_col`, out, 2: column index of the current element.
- `out_last`, out, 1: the current element is the final one (index DIM*DIM-1).
- `busy`, out, 1: high in REQ, LOAD and STREAM.
- `done`, out, 1: one-cycle pulse after the last element is transferred.

## Operation
- Element k occupies `data[ELEM_W*k +: ELEM_W]`.
  - k=0 is row0/col0.
  - row = k / DIM, col = k % DIM.
  - Streaming order is k = 0 .. DIM*DIM-1.
- FSM states are IDLE, REQ, LOAD, STREAM, DONE.
  - **IDLE:** if `start`=1, go to REQ. Otherwise stay.
  - **REQ:** `read_data`=1 for exactly this cycle. Go to LOAD.
  - **LOAD:** `read_data`=0. At the end of the cycle, latch `data` into an internal MAT_W snapshot buffer and clear the element counter k to 0. Go to STREAM.
  - **STREAM:** `out_valid`=1 and `out_data` = snapshot element k.
    - On an edge with `out_valid` && `out_ready`, the transfer completes and k increments.
    - If k was DIM*DIM-1, go to DONE instead.
  - **DONE:** `done`=1, `busy`=0. Go to IDLE.
- The stream comes only from the snapshot. Changes on `data` after LOAD do not affect the streamed values.
- `start` is ignored in every state other than IDLE. There is no queuing of requests.
- The counter is 4 bits for DIM=4 (generally clog2(DIM*DIM)). It never wraps inside a stream, because the FSM leaves STREAM on the final transfer.

## Timing
- **Reset** (asynchronous, while `reset`=0):
  - State is IDLE, the snapshot buffer and k are 0.
  - `read_data`, `out_valid`, `out_last`, `busy` and `done` are 0.
  - `out_data`, `out_row` and `out_col` are 0.
- **Reset mid-operation** (REQ, LOAD or STREAM): abort immediately. No `done` pulse. The next operation needs a fresh `start` after reset is released.
- **Latency**, with `start` sampled at edge E0:
  - `read_data` is high in cycle 1.
  - The snapshot is taken at the end of cycle 2.
  - Element 0 is valid in cycle 3.
- **Back-to-back** with `out_ready`=1 throughout:
  - Elements are in cycles 3..18.
  - `done` is in cycle 19.
  - IDLE is in cycle 20.
  - Minimum start-to-start spacing is 20 cycles.
- **Handshake:**
  - While `out_valid`=1 and `out_ready`=0, `out_data`, `out_row`, `out_col` and `out_last` hold stable.
  - `out_valid` never drops before the transfer completes.
  - `out_ready` is allowed to be high before `out_valid`. The transfer occurs on the first edge where both are high.
- **Output derivation:** `out_row`, `out_col` and `out_last` are decoded from k. They are meaningful only while `out_valid`=1 and are 0 otherwise.
- **Simultaneous `start` and `done`:** `start` in the DONE cycle is ignored. It must be re-asserted in IDLE.

## Test plan
1. **Basic unload.**
   - Stimulus: reset, then preload `data` with element k = 16'h0100+k, pulse `start`, hold `out_ready`=1.
   - Required response: `read_data` pulses in cycle 1 only. Outputs are 16'h0100..16'h010F in cycles 3..18 with row/col (0,0)..(3,3). `out_last` is high only with 16'h010F. `done` is high in cycle 19.
2. **Backpressure.**
   - Stimulus: same matrix, toggle `out_ready` 1,0,0,1,... pseudo-randomly.
   - Required response: exactly 16 transfers, in order, with no duplicates and no drops. Outputs are stable during every stall.
3. **Snapshot isolation.**
   - Stimulus: change `data` to all 16'hFFFF in cycle 4.
   - Required response: the stream still emits the original 16'h0100..16'h010F.
4. **Ignored start.**
   - Stimulus: pulse `start` during STREAM and again during DONE.
   - Required response: no additional `read_data` pulse. The FSM returns to IDLE after one `done`.
5. **Reset mid-stream.**
   - Stimulus: assert `reset` after element 5 is transferred.
   - Required response: all outputs go to 0 immediately and no `done` is produced. A new `start` after release restarts from element 0.
6. **Back-to-back unloads.**
   - Stimulus: re-assert `start` in cycle 20.
   - Required response: the second `read_data` is in cycle 21 and element 0 of the new snapshot is in cycle 23.

Source files
------------

// File: rtl/matrix_unloader.sv
// Snapshots one DIM x DIM matrix from the output register and streams it
// row-major over a valid/ready interface, one element per transfer.
module matrix_unloader #(
    parameter int ELEM_W = 16,
    parameter int DIM    = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    output logic                        o_read_data,
    input  logic [DIM*DIM*ELEM_W-1:0]   i_data,
    output logic [ELEM_W-1:0]           o_out_data,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [$clog2(DIM)-1:0]      o_out_row,
    output logic [$clog2(DIM)-1:0]      o_out_col,
    output logic                        o_out_last,
    output logic                        o_busy,
    output logic                        o_done
);
    localparam int N  = DIM * DIM;
    localparam int KW = $clog2(N);
    localparam int RW = $clog2(DIM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [N-1:0][ELEM_W-1:0] r_snap;
    logic [KW-1:0]            r_k;
    logic                     w_last;
    logic                     w_xfer;

    assign w_last = (r_k == KW'(N - 1));
    assign w_xfer = (r_state == S_STREAM) && i_out_ready;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The counter stops at the last index; the FSM leaves STREAM on that transfer.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_snap <= '0;
            r_k    <= '0;
        end else if (r_state == S_LOAD) begin
            r_snap <= i_data;
            r_k    <= '0;
        end else if (w_xfer && !w_last) begin
            r_k    <= r_k + KW'(1);
        end
    end

    always_comb begin
        w_next      = r_state;
        o_read_data = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_REQ;
            end
            S_REQ: begin
                o_read_data = 1'b1;
                o_busy      = 1'b1;
                w_next      = S_LOAD;
            end
            S_LOAD: begin
                o_busy = 1'b1;
                w_next = S_STREAM;
            end
            S_STREAM: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                if (w_xfer && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Element-side outputs read as zero whenever nothing is being offered.
    assign o_out_data = o_out_valid ? r_snap[r_k] : '0;
    assign o_out_row  = o_out_valid ? RW'(r_k / KW'(DIM)) : '0;
    assign o_out_col  = o_out_valid ? RW'(r_k % KW'(DIM)) : '0;
    assign o_out_last = o_out_valid && w_last;

endmodule

// File: tb/tb_matrix_unloader.sv
// Directed-plus-random bench for matrix_unloader: a plain matrix array is the
// reference, each stream is checked element by element against it.
module tb_matrix_unloader;
    localparam int ELEM_W = 16;
    localparam int DIM    = 4;
    localparam int N      = DIM * DIM;
    localparam int MAT_W  = N * ELEM_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
    logic [MAT_W-1:0]  data = '0;
    logic              read_data, out_valid, out_last, busy, done;
    logic [ELEM_W-1:0] out_data;
    logic [1:0]        out_row, out_col;

    int n_checks = 0;
    int n_errors = 0;
    logic [ELEM_W-1:0] mat [N];

    always #5 clk = ~clk;

    matrix_unloader #(.ELEM_W(ELEM_W), .DIM(DIM)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .o_read_data (read_data),
        .i_data      (data),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_row   (out_row),
        .o_out_col   (out_col),
        .o_out_last  (out_last),
        .o_busy      (busy),
        .o_done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: element k = 16'h0100 + k; otherwise random contents
    task automatic load_mat(input int mode);
        for (int k = 0; k < N; k++) begin
            mat[k] = (mode == 0) ? ELEM_W'(16'h0100 + k) : ELEM_W'($urandom);
            data[ELEM_W*k +: ELEM_W] = mat[k];
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rd"},    read_data, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_odata"}, out_data, 0);
        chk({tag, "_rowcol"}, {out_row, out_col}, 0);
        chk({tag, "_last"},  out_last, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
    endtask

    // Called in cycle 0 of an operation; returns in cycle 3 (first element offered).
    task automatic start_op(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_req_rd"}, read_data, 1);
        chk({tag, "_req_busy"}, busy, 1);
        chk({tag, "_req_valid"}, out_valid, 0);
        tick();
        chk({tag, "_load_rd"}, read_data, 0);
        chk({tag, "_load_busy"}, busy, 1);
        chk({tag, "_load_valid"}, out_valid, 0);
        tick();
    endtask

    // Streams the whole matrix from cycle 3 and returns in the DONE cycle.
    task automatic stream(input string tag, input bit bp, input bit iso, input bit spur);
        int k = 0;
        int cyc = 0;
        int rd = 0;
        int stalls = 0;
        logic [ELEM_W-1:0] prev = '0;
        bit stalled = 1'b0;
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        while (k < N && cyc < 200) begin
            chk({tag, "_valid"}, out_valid, 1);
            if (stalled) chk({tag, "_stall_hold"}, out_data, prev);
            chk({tag, "_data"}, out_data, mat[k]);
            chk({tag, "_rowcol"}, {out_row, out_col}, {2'(k / DIM), 2'(k % DIM)});
            chk({tag, "_last"}, out_last, (k == N - 1));
            chk({tag, "_done_early"}, done, 0);
            if (iso && cyc == 1) data = '1;
            start = spur && (cyc == 2);
            rd += int'(read_data);
            prev = out_data;
            stalled = !out_ready;
            if (out_ready) k++;
            else stalls++;
            cyc++;
            tick();
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        start = 1'b0;
        chk({tag, "_xfers"}, k, N);
        chk({tag, "_spurious_rd"}, rd, 0);
        if (!bp) chk({tag, "_cycles"}, cyc, N);
        if (bp) chk({tag, "_saw_stall"}, (stalls > 0), 1);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_busy"}, busy, 0);
        chk({tag, "_done_valid"}, out_valid, 0);
        chk({tag, "_done_row"}, {out_row, out_col, out_last}, 0);
        start = spur;
    endtask

    initial begin
        // reset state, with nonzero data presented
        load_mat(0);
        out_ready = 1'b1;
        #1;
        check_idle_outputs("rst");
        #20;
        rst_n = 1'b1;
        tick();
        check_idle_outputs("idle0");

        // basic unload, snapshot isolation (data changes in cycle 4),
        // then back-to-back with start in cycle 20
        start_op("basic");
        stream("basic", 1'b0, 1'b1, 1'b0);
        tick();
        check_idle_outputs("basic_c20");
        load_mat(1);
        start_op("b2b");
        stream("b2b", 1'b0, 1'b0, 1'b0);
        tick();
        check_idle_outputs("b2b_idle");

        // backpressure with a spurious start in STREAM and in DONE
        load_mat(0);
        tick();
        start_op("bp");
        stream("bp", 1'b1, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        check_idle_outputs("bp_after_done");
        tick();
        check_idle_outputs("bp_no_restart");

        // random matrix under backpressure
        load_mat(1);
        start_op("rnd");
        stream("rnd", 1'b1, 1'b0, 1'b0);
        tick();
        check_idle_outputs("rnd_idle");

        // reset after element 5 is transferred
        load_mat(1);
        out_ready = 1'b1;
        start_op("mid");
        for (int k = 0; k < 6; k++) begin
            chk("mid_data", out_data, mat[k]);
            tick();
        end
        chk("mid_k6", out_data, mat[6]);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_done", done, 0);
        end
        rst_n = 1'b1;
        tick();
        check_idle_outputs("mid_released");
        load_mat(0);
        start_op("restart");
        stream("restart", 1'b0, 1'b0, 1'b0);
        tick();
        check_idle_outputs("restart_idle");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
